// File: rtl/ir_nec_receiver.sv
// NEC infrared frame receiver with an Avalon-MM register interface.
// The raw line is synchronised and glitch filtered, then pulse widths are measured in 10 us ticks.
module ir_nec_receiver #(
    parameter int unsigned TICK_DIV = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    input  logic [1:0]  address,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StLeadLow,
        StLeadSpace,
        StBitLow,
        StBitSpace,
        StTrail
    } state_t;

    logic [PW-1:0] presc_q;
    logic          tick;
    logic          sync1_q, sync2_q;
    logic          filt_q;
    logic [1:0]    fcnt_q;
    logic          flip, fall, rise;
    logic [11:0]   dur_q;
    state_t        state_q;
    logic [4:0]    bit_cnt_q;
    logic [31:0]   shift_q;
    logic          is_rep_q;
    logic          timeout;
    logic [31:0]   data_q;
    logic          valid_q, rpt_q, error_q, loaded_q;
    logic          frame_done, cmd_ok;
    logic          set_valid, set_rpt, set_error, load_data;
    logic          clr_vr, clr_err;

    function automatic logic in_rng(input logic [11:0] d, input logic [11:0] lo,
                                    input logic [11:0] hi);
        return (d >= lo) && (d <= hi);
    endfunction

    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else if (tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= ir_in;
            sync2_q <= sync1_q;
        end
    end

    // The filtered level flips on the third consecutive tick that disagrees with it.
    assign flip = tick && (sync2_q != filt_q) && (fcnt_q == 2'd2);
    assign fall = flip && filt_q;
    assign rise = flip && !filt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q <= 1'b1;
            fcnt_q <= 2'd0;
        end else if (tick) begin
            if (sync2_q != filt_q) begin
                if (fcnt_q == 2'd2) begin
                    filt_q <= sync2_q;
                    fcnt_q <= 2'd0;
                end else begin
                    fcnt_q <= fcnt_q + 2'd1;
                end
            end else begin
                fcnt_q <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dur_q <= 12'd0;
        end else if (flip) begin
            dur_q <= 12'd0;
        end else if (tick && (dur_q != 12'hFFF)) begin
            dur_q <= dur_q + 12'd1;
        end
    end

    assign timeout = (state_q != StIdle) && (dur_q > 12'd1100);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 5'd0;
            shift_q   <= 32'd0;
            is_rep_q  <= 1'b0;
        end else if (timeout) begin
            state_q <= StIdle;
        end else if (flip) begin
            unique case (state_q)
                StIdle: begin
                    if (fall) state_q <= StLeadLow;
                end
                StLeadLow: begin
                    state_q <= (rise && in_rng(dur_q, 12'd800, 12'd1000)) ? StLeadSpace : StIdle;
                end
                StLeadSpace: begin
                    if (fall && in_rng(dur_q, 12'd400, 12'd500)) begin
                        state_q   <= StBitLow;
                        bit_cnt_q <= 5'd0;
                        is_rep_q  <= 1'b0;
                    end else if (fall && in_rng(dur_q, 12'd200, 12'd250)) begin
                        state_q  <= StTrail;
                        is_rep_q <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StBitLow: begin
                    state_q <= (rise && in_rng(dur_q, 12'd40, 12'd70)) ? StBitSpace : StIdle;
                end
                StBitSpace: begin
                    if (fall && (in_rng(dur_q, 12'd40, 12'd70) ||
                                 in_rng(dur_q, 12'd140, 12'd190))) begin
                        // Shifting in at the top puts the first bit at shift[0] after 32 bits.
                        shift_q   <= {in_rng(dur_q, 12'd140, 12'd190), shift_q[31:1]};
                        bit_cnt_q <= bit_cnt_q + 5'd1;
                        state_q   <= (bit_cnt_q == 5'd31) ? StTrail : StBitLow;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StTrail: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        frame_done = (state_q == StTrail) && !timeout && rise && in_rng(dur_q, 12'd40, 12'd70);
        cmd_ok     = (shift_q[23:16] == ~shift_q[31:24]);
        set_rpt    = frame_done && is_rep_q;
        set_valid  = frame_done && (is_rep_q ? loaded_q : cmd_ok);
        set_error  = frame_done && !is_rep_q && !cmd_ok;
        load_data  = frame_done && !is_rep_q && cmd_ok;
        clr_vr     = read && (address == 2'd0);
        clr_err    = read && (address == 2'd1);
    end

    // Set takes priority over a same-cycle clear; readdata reflects pre-update values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q   <= 32'd0;
            valid_q  <= 1'b0;
            rpt_q    <= 1'b0;
            error_q  <= 1'b0;
            loaded_q <= 1'b0;
            readdata <= 32'd0;
        end else begin
            if (load_data) data_q <= shift_q;
            valid_q  <= set_valid | (valid_q & ~clr_vr);
            rpt_q    <= set_rpt | (rpt_q & ~clr_vr);
            error_q  <= set_error | (error_q & ~clr_err);
            loaded_q <= loaded_q | load_data;
            if (read) begin
                unique case (address)
                    2'd0:    readdata <= data_q;
                    2'd1:    readdata <= {29'd0, error_q, rpt_q, valid_q};
                    default: readdata <= 32'd0;
                endcase
            end
        end
    end

    assign irq = valid_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
// Randomised NEC frame bench with a transaction-level model of the status/data registers.
module tb_ir_nec_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        ir_in;
    logic [1:0]  address;
    logic        read;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_data;
    logic        m_valid, m_rpt, m_err, m_loaded;
    logic [31:0] last_rd;

    ir_nec_receiver #(.TICK_DIV(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .ir_in    (ir_in),
        .address  (address),
        .read     (read),
        .readdata (readdata),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int ur(input int lo, input int hi);
        return int'($urandom_range(hi, lo));
    endfunction

    // Every stimulus task starts and ends 1 time unit after a rising clock edge.
    task automatic hold(input logic lvl, input int n);
        ir_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_data = 32'd0; m_valid = 1'b0; m_rpt = 1'b0; m_err = 1'b0; m_loaded = 1'b0;
    endtask

    task automatic m_read(input logic [1:0] a, output logic [31:0] exp);
        case (a)
            2'd0: begin exp = m_data; m_valid = 1'b0; m_rpt = 1'b0; end
            2'd1: begin exp = {29'd0, m_err, m_rpt, m_valid}; m_err = 1'b0; end
            default: exp = 32'd0;
        endcase
    endtask

    task automatic m_frame(input logic is_rep, input logic [31:0] d);
        if (is_rep) begin
            m_rpt = 1'b1;
            if (m_loaded) m_valid = 1'b1;
        end else if (d[23:16] == ~d[31:24]) begin
            m_data = d; m_valid = 1'b1; m_loaded = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endtask

    task automatic check_read(input string tag, input logic [1:0] a);
        logic [31:0] exp;
        address = a;
        read    = 1'b1;
        @(posedge clk);
        #1 read = 1'b0;
        m_read(a, exp);
        last_rd = exp;
        check_eq(tag, readdata, exp);
    endtask

    task automatic send_frame(input logic [31:0] d, input int nbits, input bit conc_rd,
                              output logic [31:0] conc_val);
        conc_val = 32'd0;
        hold(1'b0, ur(810, 990));
        hold(1'b1, ur(410, 490));
        for (int i = 0; i < nbits; i++) begin
            hold(1'b0, ur(43, 68));
            hold(1'b1, d[i] ? ur(142, 188) : ur(43, 68));
        end
        if (nbits == 32) begin
            hold(1'b0, ur(43, 68));
            if (conc_rd) begin
                // Completion is seen at the fifth edge after the trailing rise.
                ir_in = 1'b1;
                repeat (4) @(posedge clk);
                #1 address = 2'd0;
                read = 1'b1;
                @(posedge clk);
                #1 read = 1'b0;
                conc_val = readdata;
            end
            hold(1'b1, 300);
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, ur(810, 990));
        hold(1'b1, ur(205, 245));
        hold(1'b0, ur(43, 68));
        hold(1'b1, 300);
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, "_irq"}, {31'd0, irq}, {31'd0, m_valid});
        check_read({tag, "_status"}, 2'd1);
        check_read({tag, "_data"}, 2'd0);
    endtask

    function automatic logic [31:0] good_word();
        logic [7:0] a, c;
        a = 8'($urandom);
        c = 8'($urandom);
        return {~c, c, ~a, a};
    endfunction

    initial begin
        logic [31:0] d, dummy, cv, prev;
        int kind;
        reset = 1'b1; ir_in = 1'b1; read = 1'b0; address = 2'd0;
        m_reset();
        last_rd = 32'd0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("reset_readdata", readdata, 32'd0);
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        hold(1'b1, 20);
        check_read("reset_status", 2'd1);
        check_read("reset_data", 2'd0);
        check_read("reset_addr2", 2'd2);

        // Basic frame: address 0x00, command 0x45.
        send_frame(32'hBA45FF00, 32, 1'b0, dummy);
        m_frame(1'b0, 32'hBA45FF00);
        check_eq("f1_irq", {31'd0, irq}, 32'd1);
        check_read("f1_status", 2'd1);
        hold(1'b1, 10);
        check_eq("f1_hold", readdata, last_rd);
        check_read("f1_addr2", 2'd2);
        check_read("f1_addr3", 2'd3);

        send_repeat();
        m_frame(1'b1, 32'd0);
        check_read("rep_status", 2'd1);
        check_read("rep_data", 2'd0);
        check_read("rep_status2", 2'd1);

        // Command with a bad inverse byte.
        send_frame(32'h0045FF00, 32, 1'b0, dummy);
        m_frame(1'b0, 32'h0045FF00);
        check_eq("bad_irq", {31'd0, irq}, 32'd0);
        check_read("bad_status", 2'd1);
        check_read("bad_status2", 2'd1);
        check_read("bad_data", 2'd0);

        // Short glitch, short lead-in, and an out-of-window bit space.
        hold(1'b0, 2);
        hold(1'b1, 300);
        check_read("glitch_status", 2'd1);
        hold(1'b0, 600);
        hold(1'b1, 1300);
        check_read("shortlead_status", 2'd1);
        hold(1'b0, 900); hold(1'b1, 450); hold(1'b0, 50); hold(1'b1, 100);
        hold(1'b0, 50); hold(1'b1, 1300);
        check_read("badspace_status", 2'd1);

        // Reset mid-frame, then a full frame.
        send_frame(good_word(), 16, 1'b0, dummy);
        reset = 1'b1;
        hold(1'b1, 3);
        reset = 1'b0;
        m_reset();
        check_eq("midrst_readdata", readdata, 32'd0);
        hold(1'b1, 20);
        check_read("midrst_status", 2'd1);
        d = good_word();
        send_frame(d, 32, 1'b0, dummy);
        m_frame(1'b0, d);
        check_all("postrst");

        // Data read in the same cycle as completion.
        d = good_word();
        send_frame(d, 32, 1'b0, dummy);
        m_frame(1'b0, d);
        d = good_word();
        send_frame(d, 32, 1'b1, cv);
        m_read(2'd0, prev);
        m_frame(1'b0, d);
        check_eq("conc_readdata", cv, prev);
        check_all("conc");

        for (int i = 0; i < 3; i++) begin
            kind = ur(0, 2);
            if (kind == 2) begin
                send_repeat();
                m_frame(1'b1, 32'd0);
            end else begin
                d = good_word();
                if (kind == 1) d[31:24] = d[31:24] ^ (8'd1 << ur(0, 7));
                send_frame(d, 32, 1'b0, dummy);
                m_frame(1'b0, d);
            end
            check_all($sformatf("rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
